// File: rtl/calc_pi_mc.sv
// Monte Carlo pi estimator. LANES lanes each draw one LFSR point per cycle and test it
// against the quarter circle; 2^LOG2_SAMPLES samples are scaled into a fixed-point estimate.
module calc_pi_mc #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned COORD_W      = 12,
    parameter int unsigned LOG2_SAMPLES = 16,
    parameter int unsigned FRAC_W       = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             seed,
    output logic                    busy,
    output logic                    done,
    output logic [LOG2_SAMPLES:0]   hits_out,
    output logic [FRAC_W+5:0]       pi_out
);
    localparam int unsigned CNT_W = LOG2_SAMPLES + 1;
    localparam int unsigned PI_W  = FRAC_W + 6;
    localparam int unsigned SQ_W  = 2 * COORD_W;
    localparam int unsigned SUM_W = SQ_W + 1;
    localparam int unsigned N_CYC = (1 << LOG2_SAMPLES) / LANES;
    localparam int unsigned CYC_W = LOG2_SAMPLES + 1;
    localparam int unsigned SHIFT = FRAC_W + 2 - LOG2_SAMPLES;
    localparam logic [31:0] GOLDEN = 32'h9E3779B9;
    localparam logic [31:0] TAPS   = 32'h80200003;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [CYC_W-1:0]                cyc_q, cyc_d;
    logic [1:0]                      drain_q, drain_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [CNT_W-1:0]                hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                hits_out_q, hits_out_d;
    logic [PI_W-1:0]                 pi_q, pi_d;
    logic                            v1_q, v2_q, v3_q;
    logic [LANES-1:0][31:0]          lx_q, lx_d, ly_q, ly_d;
    logic [LANES-1:0][COORD_W-1:0]   x1_q, y1_q;
    logic [LANES-1:0][SQ_W-1:0]      xx2_q, yy2_q;
    logic [LANES-1:0]                hit3_q, hit_c;
    logic [CNT_W-1:0]                pop_c;
    logic                            accept_c;

    // COORD_W unrolled Galois steps so each coordinate uses fresh bits
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < int'(COORD_W); k++) begin
            r = (r >> 1) ^ (r[0] ? TAPS : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    assign accept_c = (state_q == S_IDLE) && start;

    // LFSR next state: seed on accept, step while running, hold otherwise
    always_comb begin
        lx_d = lx_q;
        ly_d = ly_q;
        for (int i = 0; i < int'(LANES); i++) begin
            if (accept_c) begin
                lx_d[i] = seed_fix(seed ^ (GOLDEN * 32'(2 * i + 1)));
                ly_d[i] = seed_fix(seed ^ (GOLDEN * 32'(2 * i + 2)));
            end else if (state_q == S_RUN) begin
                lx_d[i] = lfsr_adv(lx_q[i]);
                ly_d[i] = lfsr_adv(ly_q[i]);
            end
        end
    end

    // Inside test on the carry bit of x^2+y^2, then popcount of valid hits
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            hit_c[i] = ((SUM_W'(xx2_q[i]) + SUM_W'(yy2_q[i])) >> SQ_W) == SUM_W'(0);
            pop_c    = pop_c + CNT_W'(hit3_q[i] & v3_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hit_cnt_d  = hit_cnt_q + pop_c;
        hits_out_d = hits_out_q;
        pi_d       = pi_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    cyc_d     = '0;
                    hit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            S_RUN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(N_CYC - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                hits_out_d = hit_cnt_q;
                pi_d       = PI_W'(hit_cnt_q) << SHIFT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_cnt_q  <= '0;
            hits_out_q <= '0;
            pi_q       <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_cnt_q  <= hit_cnt_d;
            hits_out_q <= hits_out_d;
            pi_q       <= pi_d;
            v1_q       <= (state_q == S_RUN);
            v2_q       <= v1_q;
            v3_q       <= v2_q;
        end
    end

    // Datapath carries no reset; the valid chain qualifies every stage
    always_ff @(posedge clk) begin
        lx_q <= lx_d;
        ly_q <= ly_d;
        for (int i = 0; i < int'(LANES); i++) begin
            x1_q[i]   <= lx_d[i][31 -: COORD_W];
            y1_q[i]   <= ly_d[i][31 -: COORD_W];
            xx2_q[i]  <= SQ_W'(x1_q[i]) * SQ_W'(x1_q[i]);
            yy2_q[i]  <= SQ_W'(y1_q[i]) * SQ_W'(y1_q[i]);
            hit3_q[i] <= hit_c[i];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hits_out = hits_out_q;
    assign pi_out   = pi_q;

endmodule

// File: tb/tb_calc_pi_mc.sv
// Bench for calc_pi_mc: default-size instance and a small sweep instance, both checked
// against a point-by-point Monte Carlo reference model.
module tb_calc_pi_mc;
    localparam int unsigned L_A = 4, CW_A = 12, LS_A = 16;
    localparam int unsigned L_B = 1, CW_B = 4,  LS_B = 8;
    localparam int unsigned FW  = 23;
    localparam int unsigned N_A = (1 << LS_A) / L_A;
    localparam int unsigned N_B = (1 << LS_B) / L_B;
    localparam int unsigned SH_A = FW + 2 - LS_A;
    localparam int unsigned SH_B = FW + 2 - LS_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start_a, start_b;
    logic [31:0]     seed_a, seed_b;
    logic            busy_a, done_a, busy_b, done_b;
    logic [LS_A:0]   hits_a;
    logic [LS_B:0]   hits_b;
    logic [FW+5:0]   pi_a, pi_b;

    int checks   = 0;
    int failures = 0;
    int unsigned m_a1;
    logic [31:0] h_a1;

    calc_pi_mc #(.LANES(L_A), .COORD_W(CW_A), .LOG2_SAMPLES(LS_A), .FRAC_W(FW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seed(seed_a),
        .busy(busy_a), .done(done_a), .hits_out(hits_a), .pi_out(pi_a));

    calc_pi_mc #(.LANES(L_B), .COORD_W(CW_B), .LOG2_SAMPLES(LS_B), .FRAC_W(FW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed(seed_b),
        .busy(busy_b), .done(done_b), .hits_out(hits_b), .pi_out(pi_b));

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    // Reference: draw every point in issue order and count those strictly inside
    function automatic int unsigned model_hits(input int unsigned lanes, input int unsigned cw,
                                               input int unsigned log2s, input logic [31:0] s);
        logic [31:0]     xs [16];
        logic [31:0]     ys [16];
        longint unsigned x, y, lim;
        int unsigned     hits, ncyc;
        hits = 0;
        ncyc = (32'd1 << log2s) / lanes;
        lim  = 64'd1 << (2 * cw);
        for (int i = 0; i < int'(lanes); i++) begin
            xs[i] = s ^ (32'h9E3779B9 * 32'(2 * i + 1));
            ys[i] = s ^ (32'h9E3779B9 * 32'(2 * i + 2));
            if (xs[i] == 32'h0) xs[i] = 32'h1;
            if (ys[i] == 32'h0) ys[i] = 32'h1;
        end
        for (int c = 0; c < int'(ncyc); c++) begin
            for (int i = 0; i < int'(lanes); i++) begin
                for (int k = 0; k < int'(cw); k++) begin
                    xs[i] = lfsr_next(xs[i]);
                    ys[i] = lfsr_next(ys[i]);
                end
                x = 64'(xs[i] >> (32 - cw));
                y = 64'(ys[i] >> (32 - cw));
                if (x * x + y * y < lim) hits++;
            end
        end
        return hits;
    endfunction

    // Launch one run and watch a bounded window; p1/p2 are edges at which start is re-pulsed
    task automatic do_run(input bit b, input logic [31:0] s, input int p1, input int p2,
                          output logic [31:0] h, output logic [31:0] p, output int ndone,
                          output int done_at, output logic busy0, output logic busy_end);
        int n;
        n = b ? int'(N_B) : int'(N_A);
        @(negedge clk);
        if (b) begin seed_b = s; start_b = 1'b1; end
        else   begin seed_a = s; start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        busy0 = b ? busy_b : busy_a;
        ndone = 0; done_at = -1; h = '0; p = '0;
        for (int k = 1; k <= n + 20; k++) begin
            if (k == p1 || k == p2) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
            end
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            if ((b ? done_b : done_a) === 1'b1) begin
                ndone++;
                done_at = k;
                h = b ? 32'(hits_b) : 32'(hits_a);
                p = b ? 32'(pi_b) : 32'(pi_a);
            end
        end
        busy_end = b ? busy_b : busy_a;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        seed_a = $urandom; seed_b = $urandom;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
            checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done_a got=%b want=0", done_a); end
            checks++; if (hits_a !== '0) begin failures++; $display("FAIL reset_hits_a got=%0d want=0", hits_a); end
            checks++; if (pi_a !== '0) begin failures++; $display("FAIL reset_pi_a got=%0d want=0", pi_a); end
            checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin failures++; $display("FAIL reset_b busy=%b done=%b want 0/0", busy_b, done_b); end
        end
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_no_run busy_a=%b busy_b=%b want 0", busy_a, busy_b); end
    endtask

    task automatic test_default();
        logic [31:0] h, p; int nd, dat; logic b0, be; real r;
        do_run(1'b0, 32'h1, 0, 0, h, p, nd, dat, b0, be);
        checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL def_busy_rise got=%b want=1", b0); end
        checks++; if (nd != 1) begin failures++; $display("FAIL def_done_count got=%0d want=1", nd); end
        checks++; if (dat != int'(N_A + 4)) begin failures++; $display("FAIL def_done_time got=%0d want=%0d", dat, N_A + 4); end
        checks++; if (h !== 32'(m_a1)) begin failures++; $display("FAIL def_hits got=%0d want=%0d", h, m_a1); end
        checks++; if (p !== (32'(m_a1) << SH_A)) begin failures++; $display("FAIL def_pi got=%0d want=%0d", p, 32'(m_a1) << SH_A); end
        r = real'(p) / 8388608.0;
        checks++; if (!(r >= 3.09 && r <= 3.19)) begin failures++; $display("FAIL def_pi_range got=%f want 3.09..3.19", r); end
        checks++; if (be !== 1'b0) begin failures++; $display("FAIL def_busy_end got=%b want=0", be); end
        checks++; if (32'(hits_a) !== h) begin failures++; $display("FAIL def_hold got=%0d want=%0d", hits_a, h); end
        h_a1 = h;
    endtask

    task automatic test_ignored_start();
        logic [31:0] h, p; int nd, dat; logic b0, be;
        do_run(1'b0, 32'h1, 5, 100, h, p, nd, dat, b0, be);
        checks++; if (nd != 1) begin failures++; $display("FAIL ign_done_count got=%0d want=1", nd); end
        checks++; if (dat != int'(N_A + 4)) begin failures++; $display("FAIL ign_done_time got=%0d want=%0d", dat, N_A + 4); end
        checks++; if (h !== 32'(m_a1)) begin failures++; $display("FAIL ign_hits got=%0d want=%0d", h, m_a1); end
    endtask

    task automatic test_zero_seed();
        logic [31:0] h, p; int nd, dat; logic b0, be; int unsigned m;
        m = model_hits(L_A, CW_A, LS_A, 32'h9E3779B9);
        do_run(1'b0, 32'h9E3779B9, 0, 0, h, p, nd, dat, b0, be);
        checks++; if (nd != 1 || h !== 32'(m)) begin failures++; $display("FAIL zero_seed_hits got=%0d done=%0d want=%0d done=1", h, nd, m); end
        checks++; if (p !== (32'(m) << SH_A)) begin failures++; $display("FAIL zero_seed_pi got=%0d want=%0d", p, 32'(m) << SH_A); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] h, p; int nd, dat; logic b0, be;
        @(negedge clk); seed_a = 32'h1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (199) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done_a); end
        checks++; if (hits_a !== '0 || pi_a !== '0) begin failures++; $display("FAIL abort_outputs hits=%0d pi=%0d want 0", hits_a, pi_a); end
        do_run(1'b0, 32'h1, 0, 0, h, p, nd, dat, b0, be);
        checks++; if (nd != 1 || dat != int'(N_A + 4)) begin failures++; $display("FAIL abort_rerun_done count=%0d at=%0d want 1 at %0d", nd, dat, N_A + 4); end
        checks++; if (h !== h_a1 || h !== 32'(m_a1)) begin failures++; $display("FAIL abort_rerun_hits got=%0d want=%0d", h, m_a1); end
    endtask

    task automatic test_small_sweep();
        logic [31:0] h, p; int nd, dat; logic b0, be; int unsigned m;
        m = model_hits(L_B, CW_B, LS_B, 32'h1);
        do_run(1'b1, 32'h1, 0, 0, h, p, nd, dat, b0, be);
        checks++; if (nd != 1 || dat != int'(N_B + 4)) begin failures++; $display("FAIL small_done count=%0d at=%0d want 1 at %0d", nd, dat, N_B + 4); end
        checks++; if (h > 32'd256) begin failures++; $display("FAIL small_bound got=%0d want<=256", h); end
        checks++; if (h !== 32'(m)) begin failures++; $display("FAIL small_hits got=%0d want=%0d", h, m); end
        checks++; if (p !== (32'(m) << SH_B)) begin failures++; $display("FAIL small_pi got=%0d want=%0d", p, 32'(m) << SH_B); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h1, h2, h3, p; int nd, dat; logic b0, be; int unsigned m1, m2;
        m1 = model_hits(L_B, CW_B, LS_B, 32'h1);
        m2 = model_hits(L_B, CW_B, LS_B, 32'h2);
        do_run(1'b1, 32'h1, 0, 0, h1, p, nd, dat, b0, be);
        do_run(1'b1, 32'h2, 0, 0, h2, p, nd, dat, b0, be);
        checks++; if (h2 !== 32'(m2)) begin failures++; $display("FAIL b2b_seed2 got=%0d want=%0d", h2, m2); end
        if (m1 != m2) begin
            checks++; if (h1 === h2) begin failures++; $display("FAIL b2b_differ seed1=%0d seed2=%0d want different", h1, h2); end
        end
        do_run(1'b1, 32'h1, 0, 0, h3, p, nd, dat, b0, be);
        checks++; if (h3 !== h1 || h3 !== 32'(m1)) begin failures++; $display("FAIL b2b_repeat got=%0d want=%0d", h3, m1); end
    endtask

    task automatic test_random_seeds();
        logic [31:0] s, h, p; int nd, dat; logic b0, be; int unsigned m;
        for (int r = 0; r < 3; r++) begin
            s = $urandom;
            m = model_hits(L_B, CW_B, LS_B, s);
            do_run(1'b1, s, int'($urandom_range(2, N_B + 4)), int'($urandom_range(2, N_B + 4)),
                   h, p, nd, dat, b0, be);
            checks++; if (nd != 1 || dat != int'(N_B + 4)) begin failures++; $display("FAIL rand_done seed=%h count=%0d at=%0d", s, nd, dat); end
            checks++; if (h !== 32'(m) || p !== (32'(m) << SH_B)) begin failures++; $display("FAIL rand_result seed=%h hits=%0d pi=%0d want hits=%0d", s, h, p, m); end
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; seed_a = '0; seed_b = '0;
        m_a1 = model_hits(L_A, CW_A, LS_A, 32'h1);
        test_reset();
        test_default();
        test_ignored_start();
        test_zero_seed();
        test_reset_mid_run();
        test_small_sweep();
        test_back_to_back();
        test_random_seeds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
